// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings, FSM states and lane-mask helper for dmem_responder
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Byte lanes touched by an access of the given size at the given lane offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << lane;
      SZ_HALF: lane_mask = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response handshake bundle between datapath and responder
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/byte_lane_ram.sv
// rtl/byte_lane_ram.sv - single-port 32-bit RAM with per-byte write enables and registered read
module byte_lane_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Write enabled lanes and capture the pre-write word on every enabled cycle.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-stated data-memory responder with alignment and range checks
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept, go_resp;
  logic        we_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic        cur_we, cur_err;
  logic [1:0]  cur_size;
  logic [31:0] cur_addr, cur_wdata, ram_wdata, ram_rdata, shifted, aligned;
  logic [3:0]  ram_we;

  // In IDLE the request comes straight off the bus so a zero-wait access can hit the RAM on the accept edge.
  always_comb begin
    cur_we    = (state == ST_IDLE) ? bus.req_we    : we_q;
    cur_size  = (state == ST_IDLE) ? bus.req_size  : size_q;
    cur_addr  = (state == ST_IDLE) ? bus.req_addr  : addr_q;
    cur_wdata = (state == ST_IDLE) ? bus.req_wdata : wdata_q;
    cur_err   = 1'b0;
    if (cur_size == SZ_ILL) cur_err = 1'b1;
    if (cur_size == SZ_HALF && cur_addr[0]) cur_err = 1'b1;
    if (cur_size == SZ_WORD && cur_addr[1:0] != 2'b00) cur_err = 1'b1;
    if (cur_addr[31:AW+2] != '0) cur_err = 1'b1;
    ram_we = (cur_we && !cur_err) ? lane_mask(cur_size, cur_addr[1:0]) : 4'b0000;
    case (cur_size)
      SZ_BYTE: ram_wdata = {4{cur_wdata[7:0]}};
      SZ_HALF: ram_wdata = {2{cur_wdata[15:0]}};
      default: ram_wdata = cur_wdata;
    endcase
  end

  // Next-state logic: count wait states, hold RESP until the requester takes it.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    go_resp   = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          cnt_nxt = 4'd0;
          if (WAIT_CYCLES == 0) begin
            state_nxt = ST_RESP;
            go_resp   = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == CNT_LAST) begin
          state_nxt = ST_RESP;
          go_resp   = 1'b1;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, counter and error flag; reset abandons any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (go_resp) err_q <= cur_err;
    end
  end

  // Request latch; only meaningful while a transaction is in flight, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.req_we;
      size_q  <= bus.req_size;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  byte_lane_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .en   (go_resp && !rst),
    .we   (ram_we),
    .addr (cur_addr[AW+1:2]),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  // Right-justify and zero-extend the registered RAM word for the latched access.
  always_comb begin
    shifted = ram_rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      SZ_BYTE: aligned = {24'b0, shifted[7:0]};
      SZ_HALF: aligned = {16'b0, shifted[15:0]};
      default: aligned = shifted;
    endcase
  end

  assign bus.req_ready  = (state == ST_IDLE) && !rst;
  assign bus.resp_valid = (state == ST_RESP);
  assign bus.resp_err   = (state == ST_RESP) && err_q;
  assign bus.resp_rdata = (state == ST_RESP && !we_q && !err_q) ? aligned : 32'b0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder at two wait-state settings
module tb_dmem_responder;
  import mem_pkg::*;

  localparam int DEPTH = 1024;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;

  logic        t_valid = 1'b0, t_we = 1'b0, t_rready = 1'b0;
  logic [1:0]  t_size  = 2'b00;
  logic [31:0] t_addr  = '0, t_wdata = '0;
  logic        o_req_ready, o_resp_valid, o_resp_err;
  logic [31:0] o_resp_rdata;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   wc       = 2;
  exp_t e;
  exp_t exp_q[$];
  logic [7:0] mem_model [bit [32:0]];

  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;

  assign bus_a.req_valid  = t_valid & ~sel;
  assign bus_b.req_valid  = t_valid & sel;
  assign bus_a.resp_ready = t_rready & ~sel;
  assign bus_b.resp_ready = t_rready & sel;
  assign bus_a.req_we     = t_we;
  assign bus_b.req_we     = t_we;
  assign bus_a.req_size   = t_size;
  assign bus_b.req_size   = t_size;
  assign bus_a.req_addr   = t_addr;
  assign bus_b.req_addr   = t_addr;
  assign bus_a.req_wdata  = t_wdata;
  assign bus_b.req_wdata  = t_wdata;

  assign o_req_ready  = sel ? bus_b.req_ready  : bus_a.req_ready;
  assign o_resp_valid = sel ? bus_b.resp_valid : bus_a.resp_valid;
  assign o_resp_rdata = sel ? bus_b.resp_rdata : bus_a.resp_rdata;
  assign o_resp_err   = sel ? bus_b.resp_err   : bus_a.resp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic model_push(input logic we, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata);
    exp_t x;
    int   n;
    x     = '0;
    n     = 1 << size;
    x.err = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
            (size == 2'b10 && addr[1:0] != 2'b00) || (addr >= 32'(4 * DEPTH));
    if (!x.err) begin
      for (int i = 0; i < n; i++) begin
        if (we) mem_model[{sel, addr + 32'(i)}] = wdata[8*i +: 8];
        else    x.rdata[8*i +: 8] = mem_model[{sel, addr + 32'(i)}];
      end
    end
    exp_q.push_back(x);
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold, input logic pre_next,
                        input logic [31:0] nxt_addr);
    int guard;
    int lat;
    exp_t x;
    wc = sel ? 0 : 2;
    model_push(we, size, addr, wdata);
    t_valid = 1'b1; t_we = we; t_size = size; t_addr = addr; t_wdata = wdata;
    guard = 0;
    while (!o_req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_before_accept", o_req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    t_valid = 1'b0;
    lat = 1;
    while (!o_resp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(wc + 1));
    x = exp_q.pop_front();
    check("rdata", o_resp_rdata, x.rdata);
    check("err", o_resp_err, x.err);
    for (int i = 0; i < hold; i++) begin
      if (pre_next && i == 0) begin
        t_valid = 1'b1; t_we = 1'b0; t_size = SZ_WORD; t_addr = nxt_addr; t_wdata = '0;
      end
      @(negedge clk);
      check("hold_valid", o_resp_valid, 1);
      check("hold_rdata", o_resp_rdata, x.rdata);
      check("hold_req_ready", o_req_ready, 0);
    end
    t_rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    t_rready = 1'b0;
    check("consumed_valid", o_resp_valid, 0);
    check("idle_req_ready", o_req_ready, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_req_ready_a", bus_a.req_ready, 0);
    check("rst_req_ready_b", bus_b.req_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_req_ready_a", bus_a.req_ready, 1);
    check("reset_resp_valid_a", bus_a.resp_valid, 0);
    check("reset_rdata_a", bus_a.resp_rdata, 0);
    check("reset_err_a", bus_a.resp_err, 0);
    check("reset_req_ready_b", bus_b.req_ready, 1);
    check("reset_resp_valid_b", bus_b.resp_valid, 0);

    // Basic word store/load with two wait states
    do_req(1, SZ_WORD, 32'h10, 32'hDEADBEEF, 0, 0, 0);
    do_req(0, SZ_WORD, 32'h10, 32'h0, 0, 0, 0);

    // Byte/half merge into an existing word
    do_req(1, SZ_WORD, 32'h20, 32'h11223344, 0, 0, 0);
    do_req(1, SZ_BYTE, 32'h21, 32'h000000AA, 0, 0, 0);
    do_req(1, SZ_HALF, 32'h22, 32'h0000BEEF, 0, 0, 0);
    do_req(0, SZ_WORD, 32'h20, 32'h0, 0, 0, 0);
    do_req(0, SZ_BYTE, 32'h23, 32'h0, 0, 0, 0);
    do_req(0, SZ_HALF, 32'h22, 32'h0, 0, 0, 0);

    // Error cases must not disturb memory
    do_req(1, SZ_WORD, 32'h0, 32'h55555555, 0, 0, 0);
    do_req(0, SZ_HALF, 32'h21, 32'h0, 0, 0, 0);
    do_req(1, SZ_WORD, 32'h22, 32'hFFFFFFFF, 0, 0, 0);
    do_req(1, SZ_ILL,  32'h20, 32'hFFFFFFFF, 0, 0, 0);
    do_req(0, SZ_ILL,  32'h20, 32'h0, 0, 0, 0);
    do_req(1, SZ_WORD, 32'(4 * DEPTH), 32'hFFFFFFFF, 0, 0, 0);
    do_req(0, SZ_WORD, 32'(4 * DEPTH), 32'h0, 0, 0, 0);
    do_req(0, SZ_WORD, 32'h20, 32'h0, 0, 0, 0);
    do_req(0, SZ_WORD, 32'h0, 32'h0, 0, 0, 0);

    // Backpressure with a second request waiting on the bus
    do_req(0, SZ_WORD, 32'h20, 32'h0, 5, 1, 32'h10);
    do_req(0, SZ_WORD, 32'h10, 32'h0, 0, 0, 0);

    // Reset during WAIT drops the store
    do_req(1, SZ_WORD, 32'h40, 32'hCAFEF00D, 0, 0, 0);
    t_valid = 1'b1; t_we = 1'b1; t_size = SZ_WORD; t_addr = 32'h40; t_wdata = 32'h12345678;
    check("rst_test_ready", o_req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    t_valid = 1'b0;
    check("rst_test_in_wait", o_req_ready, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_resp_valid", o_resp_valid, 0);
    check("midrst_rdata", o_resp_rdata, 0);
    check("midrst_err", o_resp_err, 0);
    check("midrst_req_ready", o_req_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_req_ready", o_req_ready, 1);
    check("postrst_resp_valid", o_resp_valid, 0);
    do_req(0, SZ_WORD, 32'h40, 32'h0, 0, 0, 0);

    // Zero wait states: fill, then back-to-back loads with resp_ready held high
    sel = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      do_req(1, SZ_WORD, 32'(4 * k), 32'hA5000000 + 32'(k * 32'h01010101), 0, 0, 0);
    end
    do_req(1, SZ_BYTE, 32'h9, 32'h0000007E, 0, 0, 0);
    t_rready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      model_push(0, SZ_WORD, 32'(4 * k), 32'h0);
      t_valid = 1'b1; t_we = 1'b0; t_size = SZ_WORD; t_addr = 32'(4 * k); t_wdata = '0;
      check("b2b_req_ready", o_req_ready, 1);
      @(posedge clk);
      @(negedge clk);
      check("b2b_resp_valid", o_resp_valid, 1);
      check("b2b_req_ready_low", o_req_ready, 0);
      e = exp_q.pop_front();
      check("b2b_rdata", o_resp_rdata, e.rdata);
      check("b2b_err", o_resp_err, e.err);
      @(posedge clk);
      @(negedge clk);
    end
    t_valid  = 1'b0;
    t_rready = 1'b0;
    @(negedge clk);
    check("b2b_idle", o_resp_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
